// File: rtl/dp_ram_bist_ctrl.sv
// March C- BIST controller for a 1R/1W dual-port RAM (read port A, write port B).
// Optional build macro: DP_RAM_BIST_STOP_ON_FAIL_EN ends the run on the first mismatch.
module dp_ram_bist_ctrl #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  FAIL,
  output logic [ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [2:0]            FAIL_ELEM,
  output logic [ADDR_WIDTH-1:0] AA,
  output logic                  CEA,
  output logic                  RDWENA,
  output logic [ADDR_WIDTH-1:0] AB,
  output logic [DATA_WIDTH-1:0] DB,
  output logic [DATA_WIDTH-1:0] BWB,
  output logic                  CEB,
  output logic                  RDWENB,
  input  logic [DATA_WIDTH-1:0] QA,
  output logic [2:0]            DBG_STATE
);

  typedef enum logic [2:0] {IDLE = 3'd0, EL0, RD, WR, EL5, DRAIN, FIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] A_MAX  = '1;
  localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] D_ONES = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [2:0]            elem;
  logic [DATA_WIDTH-1:0] rd_exp;
  logic [2:0]            rd_elem;
  logic                  cmp_vld;
  logic [DATA_WIDTH-1:0] cmp_exp;
  logic [ADDR_WIDTH-1:0] cmp_addr;
  logic [2:0]            cmp_elem;
  logic                  mism;

  function automatic logic is_down(input logic [2:0] e);
    is_down = (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rd_pat(input logic [2:0] e);
    rd_pat = ((e == 3'd2) || (e == 3'd4)) ? D_ONES : '0;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] wr_pat(input logic [2:0] e);
    wr_pat = ((e == 3'd1) || (e == 3'd3)) ? D_ONES : '0;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] first_addr(input logic [2:0] e);
    first_addr = is_down(e) ? A_MAX : '0;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] last_addr(input logic [2:0] e);
    last_addr = is_down(e) ? '0 : A_MAX;
  endfunction

  // QA belongs to the read issued one cycle earlier; cmp_* carry that read's context.
  assign mism      = cmp_vld && (QA != cmp_exp);
  assign RDWENA    = 1'b1;
  assign DBG_STATE = state;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      addr      <= '0;
      elem      <= 3'd0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      FAIL      <= 1'b0;
      FAIL_ADDR <= '0;
      FAIL_ELEM <= 3'd0;
      AA        <= '0;
      CEA       <= 1'b0;
      AB        <= '0;
      DB        <= '0;
      BWB       <= '0;
      CEB       <= 1'b0;
      RDWENB    <= 1'b1;
      rd_exp    <= '0;
      rd_elem   <= 3'd0;
      cmp_vld   <= 1'b0;
      cmp_exp   <= '0;
      cmp_addr  <= '0;
      cmp_elem  <= 3'd0;
    end else begin
      CEA      <= 1'b0;
      CEB      <= 1'b0;
      RDWENB   <= 1'b1;
      DONE     <= 1'b0;
      cmp_vld  <= CEA;
      cmp_exp  <= rd_exp;
      cmp_addr <= AA;
      cmp_elem <= rd_elem;
      // Outputs are registered together with the state that owns them.
      case (state)
        IDLE: if (START) begin
          state     <= EL0;
          addr      <= '0;
          elem      <= 3'd0;
          BUSY      <= 1'b1;
          FAIL      <= 1'b0;
          FAIL_ADDR <= '0;
          FAIL_ELEM <= 3'd0;
          CEB       <= 1'b1;
          RDWENB    <= 1'b0;
          AB        <= '0;
          DB        <= wr_pat(3'd0);
          BWB       <= D_ONES;
        end
        EL0: if (addr == A_MAX) begin
          state   <= RD;
          elem    <= 3'd1;
          addr    <= first_addr(3'd1);
          CEA     <= 1'b1;
          AA      <= first_addr(3'd1);
          rd_exp  <= rd_pat(3'd1);
          rd_elem <= 3'd1;
        end else begin
          addr   <= addr + A_ONE;
          CEB    <= 1'b1;
          RDWENB <= 1'b0;
          AB     <= addr + A_ONE;
          DB     <= wr_pat(elem);
          BWB    <= D_ONES;
        end
        RD: begin
          state  <= WR;
          CEB    <= 1'b1;
          RDWENB <= 1'b0;
          AB     <= addr;
          DB     <= wr_pat(elem);
          BWB    <= D_ONES;
        end
        WR: if (addr == last_addr(elem)) begin
          state   <= (elem == 3'd4) ? EL5 : RD;
          elem    <= elem + 3'd1;
          addr    <= first_addr(elem + 3'd1);
          CEA     <= 1'b1;
          AA      <= first_addr(elem + 3'd1);
          rd_exp  <= rd_pat(elem + 3'd1);
          rd_elem <= elem + 3'd1;
        end else begin
          state   <= RD;
          addr    <= is_down(elem) ? addr - A_ONE : addr + A_ONE;
          CEA     <= 1'b1;
          AA      <= is_down(elem) ? addr - A_ONE : addr + A_ONE;
          rd_exp  <= rd_pat(elem);
          rd_elem <= elem;
        end
        EL5: if (addr == A_MAX) begin
          state <= DRAIN;
        end else begin
          addr    <= addr + A_ONE;
          CEA     <= 1'b1;
          AA      <= addr + A_ONE;
          rd_exp  <= rd_pat(elem);
          rd_elem <= elem;
        end
        DRAIN: begin
          state <= FIN;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
      if (mism && !FAIL) begin
        FAIL      <= 1'b1;
        FAIL_ADDR <= cmp_addr;
        FAIL_ELEM <= cmp_elem;
`ifdef DP_RAM_BIST_STOP_ON_FAIL_EN
        state  <= FIN;
        BUSY   <= 1'b0;
        DONE   <= 1'b1;
        CEA    <= 1'b0;
        CEB    <= 1'b0;
        RDWENB <= 1'b1;
`else
`endif
      end
    end
  end

endmodule
